// File: rtl/hex_display_scheduler.sv
// Round-robin time-sharing of the two-digit hex display among four byte requesters.
// Optional HEX_SCHED_FREEZE_EN adds a freeze input that holds the current slot.
module hex_display_scheduler #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] values,
`ifdef HEX_SCHED_FREEZE_EN
  input  logic        freeze,
`endif
  output logic [7:0]  disp_value,
  output logic [1:0]  disp_src,
  output logic        disp_valid,
  output logic [3:0]  grant,
  output logic        slot_start
);

  typedef enum logic {IDLE, SHOW} state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       src_q, src_d;
  logic             valid_q, valid_d;
  logic [7:0]       value_q, value_d;
  logic             slot_start_q, slot_start_d;

  logic             frz;
  logic             win_ok;
  logic [1:0]       win_idx;
  logic             expire;
  logic             drop;

`ifdef HEX_SCHED_FREEZE_EN
  assign frz = freeze && (state_q == SHOW);
`else
  assign frz = 1'b0;
`endif

  // Search order starts just after the last winner and ends on it.
  always_comb begin
    win_ok  = 1'b0;
    win_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!win_ok && req[last_q + 2'(k)]) begin
        win_ok  = 1'b1;
        win_idx = last_q + 2'(k);
      end
    end
  end

  assign expire = (cnt_q == LAST_CNT) && !frz;
  assign drop   = !req[src_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    grant_d      = grant_q;
    src_d        = src_q;
    valid_d      = valid_q;
    value_d      = value_q;
    slot_start_d = 1'b0;

    if (state_q == IDLE || expire || drop) begin
      if (win_ok) begin
        state_d      = SHOW;
        cnt_d        = '0;
        last_d       = win_idx;
        grant_d      = 4'b0001 << win_idx;
        src_d        = win_idx;
        valid_d      = 1'b1;
        value_d      = values[{win_idx, 3'b000} +: 8];
        slot_start_d = 1'b1;
      end else begin
        // disp_value deliberately keeps its last byte when going idle.
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = 4'b0000;
        src_d   = 2'd0;
        valid_d = 1'b0;
      end
    end else if (!frz) begin
      cnt_d   = cnt_q + 1'b1;
      value_d = values[{src_q, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= 2'd3;
      grant_q      <= 4'b0000;
      src_q        <= 2'd0;
      valid_q      <= 1'b0;
      value_q      <= 8'h00;
      slot_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      src_q        <= src_d;
      valid_q      <= valid_d;
      value_q      <= value_d;
      slot_start_q <= slot_start_d;
    end
  end

  assign disp_value = value_q;
  assign disp_src   = src_q;
  assign disp_valid = valid_q;
  assign grant      = grant_q;
  assign slot_start = slot_start_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed self-checking bench for hex_display_scheduler with DWELL_CYCLES = 4.
module tb_hex_display_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] values;
`ifdef HEX_SCHED_FREEZE_EN
  logic        freeze;
`endif
  logic [7:0]  disp_value;
  logic [1:0]  disp_src;
  logic        disp_valid;
  logic [3:0]  grant;
  logic        slot_start;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_display_scheduler #(.DWELL_CYCLES(4), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .values     (values),
`ifdef HEX_SCHED_FREEZE_EN
    .freeze     (freeze),
`endif
    .disp_value (disp_value),
    .disp_src   (disp_src),
    .disp_valid (disp_valid),
    .grant      (grant),
    .slot_start (slot_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic [7:0] b, input logic ss);
    check({tag, ".grant"},      32'(grant),      32'(g));
    check({tag, ".disp_src"},   32'(disp_src),   32'(s));
    check({tag, ".disp_valid"}, 32'(disp_valid), 32'(v));
    check({tag, ".disp_value"}, 32'(disp_value), 32'(b));
    check({tag, ".slot_start"}, 32'(slot_start), 32'(ss));
  endtask

  initial begin
    req    = 4'b0000;
    values = 32'h0;
`ifdef HEX_SCHED_FREEZE_EN
    freeze = 1'b0;
`endif

    // Reset state and idle with no requests.
    do_reset();
    check_all("reset", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);
    step();
    check_all("idle", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);

    // Sole requester: re-granted every 4 cycles with a fresh slot_start.
    req    = 4'b0001;
    values = 32'h0000_00A5;
    step();
    check_all("sole.first", 4'b0001, 2'd0, 1'b1, 8'hA5, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      step();
      check($sformatf("sole.c%0d.slot_start", n), 32'(slot_start), 32'((n % 4) == 0));
      check($sformatf("sole.c%0d.grant", n), 32'(grant), 32'h1);
    end

    // All four requesting: rotation 0,1,2,3,0 with 4 cycles each and no gaps.
    do_reset();
    req    = 4'b1111;
    values = 32'h3020_1000;
    for (int n = 0; n < 20; n++) begin
      step();
      check($sformatf("rr.c%0d.grant", n), 32'(grant), 32'(4'b0001 << ((n / 4) % 4)));
      check($sformatf("rr.c%0d.value", n), 32'(disp_value), 32'(8'h10 * ((n / 4) % 4)));
      check($sformatf("rr.c%0d.slot_start", n), 32'(slot_start), 32'((n % 4) == 0));
    end

    // Owner 2 drops in cycle 1 of its slot while requester 0 still wants time.
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 10; n++) step();
    check("drop.owner_before", 32'(grant), 32'h4);
    req = 4'b0001;
    step();
    check_all("drop.handover", 4'b0001, 2'd0, 1'b1, 8'h00, 1'b1);

    // All requests drop; the displayed byte is held even though the source changes.
    req    = 4'b0000;
    values = 32'h3020_10EE;
    step();
    check_all("alldrop", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);
    step();
    check_all("alldrop.stay", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);

    // Pointer continues after last winner 0: requester 3 is searched before 0 wraps.
    req = 4'b1001;
    step();
    check_all("resume", 4'b1000, 2'd3, 1'b1, 8'h30, 1'b1);

    // Live value update inside a slot, then reset mid-slot.
    do_reset();
    req    = 4'b0010;
    values = 32'h0000_3C00;
    step();
    check_all("live.first", 4'b0010, 2'd1, 1'b1, 8'h3C, 1'b1);
    values = 32'h0000_C300;
    check("live.before", 32'(disp_value), 32'h3C);
    step();
    check("live.after", 32'(disp_value), 32'hC3);
    reset = 1'b1;
    step();
    check_all("midreset", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    req   = 4'b0011;
    values = 32'h0000_C35A;
    step();
    check_all("postreset", 4'b0001, 2'd0, 1'b1, 8'h5A, 1'b1);

`ifdef HEX_SCHED_FREEZE_EN
    // Freeze for 10 cycles after two counted cycles; slot ends two edges after release.
    do_reset();
    req    = 4'b0001;
    values = 32'h0000_0011;
    step();
    check_all("frz.first", 4'b0001, 2'd0, 1'b1, 8'h11, 1'b1);
    step();
    step();
    freeze = 1'b1;
    values = 32'h0000_0022;
    for (int n = 0; n < 10; n++) begin
      step();
      check($sformatf("frz.c%0d.grant", n), 32'(grant), 32'h1);
      check($sformatf("frz.c%0d.value", n), 32'(disp_value), 32'h11);
      check($sformatf("frz.c%0d.slot_start", n), 32'(slot_start), 32'h0);
    end
    freeze = 1'b0;
    step();
    check("frz.rel1.slot_start", 32'(slot_start), 32'h0);
    check("frz.rel1.value", 32'(disp_value), 32'h22);
    step();
    check("frz.rel2.slot_start", 32'(slot_start), 32'h1);
    check("frz.rel2.grant", 32'(grant), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
